// File: rtl/multadd_pkg.sv
// multadd_pkg: shared types and width helpers for the multadd arbiter slice.
//   - FSM state encoding (RUN, DRAIN)
//   - default configuration and width helpers (ID_W, RES_W)
//   - pipeline stage layout for the default configuration
package multadd_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LAT_DEF    = 2;

  // Legacy encodings kept so external tooling that decodes the state sees the same values.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef enum logic [0:0] {
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned res_w(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

  localparam int unsigned ID_W  = id_w(N_REQ_DEF);
  localparam int unsigned RES_W = res_w(DATA_W_DEF);

  // Each stage carries the product and addend; the final add is done on the output stage.
  typedef struct packed {
    logic                      valid;
    logic [ID_W-1:0]           id;
    logic [2*DATA_W_DEF-1:0]   prod;
    logic [2*DATA_W_DEF-1:0]   c;
  } stage_t;

endpackage

// File: rtl/multadd_pipe.sv
// multadd_pipe: LAT-deep multiply-add pipeline (result = a*b + c) with a
// global advance enable. All stages shift together when adv_i=1, else hold.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   adv_i               shift enable for every stage
//   in_valid_i/in_id_i  operation entering stage 1 and its requester id
//   in_a_i/in_b_i/in_c_i operands
//   out_valid_o/out_id_o/out_data_o  output stage contents
//   busy_o              any stage (including output) holds a valid op
module multadd_pipe
  import multadd_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned N_REQ  = N_REQ_DEF,
  parameter  int unsigned LAT    = LAT_DEF,
  localparam int unsigned IW     = id_w(N_REQ),
  localparam int unsigned RW     = res_w(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv_i,
  input  logic                in_valid_i,
  input  logic [IW-1:0]       in_id_i,
  input  logic [DATA_W-1:0]   in_a_i,
  input  logic [DATA_W-1:0]   in_b_i,
  input  logic [2*DATA_W-1:0] in_c_i,
  output logic                out_valid_o,
  output logic [IW-1:0]       out_id_o,
  output logic [RW-1:0]       out_data_o,
  output logic                busy_o
);

  // Same layout as multadd_pkg::stage_t, sized by this instance's parameters.
  typedef struct packed {
    logic                valid;
    logic [IW-1:0]       id;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] c;
  } pstage_t;

  pstage_t stg_q [LAT];
  pstage_t stg_d [LAT];

  always_comb begin
    stg_d[0].valid = in_valid_i;
    stg_d[0].id    = in_id_i;
    stg_d[0].prod  = {{DATA_W{1'b0}}, in_a_i} * {{DATA_W{1'b0}}, in_b_i};
    stg_d[0].c     = in_c_i;
    for (int unsigned s = 1; s < LAT; s++) begin
      stg_d[s] = stg_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        stg_q[s] <= '0;
      end
    end else if (adv_i) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        stg_q[s] <= stg_d[s];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned s = 0; s < LAT; s++) begin
      busy_o = busy_o | stg_q[s].valid;
    end
  end

  assign out_valid_o = stg_q[LAT-1].valid;
  assign out_id_o    = stg_q[LAT-1].id;
  assign out_data_o  = {1'b0, stg_q[LAT-1].prod} + {1'b0, stg_q[LAT-1].c};

endmodule

// File: rtl/multadd_arbiter.sv
// multadd_arbiter: round-robin arbiter sharing one pipelined multiply-add
// unit among N_REQ requesters, with result backpressure and flush/drain.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        per-requester handshake (req_ready one-hot or 0)
//   req_a/req_b/req_c          packed operands, requester i at slice i
//   rsp_valid/rsp_ready        result handshake
//   rsp_id/rsp_data            originating requester and a*b+c
//   flush/flush_done           stop granting and drain / drained indication
// Optional (macro MULTADD_ARB_STATS_EN):
//   stat_sel/stat_cnt          combinational read of 16-bit saturating
//                              per-requester accept counters
module multadd_arbiter
  import multadd_pkg::*;
#(
  parameter  int unsigned N_REQ  = N_REQ_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned LAT    = LAT_DEF,
  localparam int unsigned IW     = id_w(N_REQ),
  localparam int unsigned RW     = res_w(DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*2*DATA_W-1:0] req_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IW-1:0]             rsp_id,
  output logic [RW-1:0]             rsp_data,
  input  logic                      flush,
  output logic                      flush_done
`ifdef MULTADD_ARB_STATS_EN
  ,
  input  logic [IW-1:0]             stat_sel,
  output logic [15:0]               stat_cnt
`endif
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          fd_q, fd_d;
  logic          adv;
  logic          accept;
  logic          busy;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  int unsigned   idx;

  assign adv = !rsp_valid || rsp_ready;

  // Round-robin search starting at the pointer; the rst term keeps req_ready
  // low while reset is held even if requesters are already valid.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (!rst && state_q == RUN && adv) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (gnt == '0 && req_valid[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = IW'(idx);
        end
      end
    end
  end

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (32'(gnt_idx) + 1 == N_REQ) ? '0 : gnt_idx + 1'b1;
    end
    state_d = flush ? DRAIN : RUN;
    fd_d    = (state_q == DRAIN) && flush && !busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fd_q    <= fd_d;
    end
  end

  // Registered done is masked by flush so it drops in the same cycle flush does.
  assign flush_done = fd_q && flush;

  multadd_pipe #(
    .DATA_W (DATA_W),
    .N_REQ  (N_REQ),
    .LAT    (LAT)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .adv_i       (adv),
    .in_valid_i  (accept),
    .in_id_i     (gnt_idx),
    .in_a_i      (req_a[gnt_idx*DATA_W +: DATA_W]),
    .in_b_i      (req_b[gnt_idx*DATA_W +: DATA_W]),
    .in_c_i      (req_c[gnt_idx*2*DATA_W +: 2*DATA_W]),
    .out_valid_o (rsp_valid),
    .out_id_o    (rsp_id),
    .out_data_o  (rsp_data),
    .busy_o      (busy)
  );

`ifdef MULTADD_ARB_STATS_EN
  logic [15:0] cnt_q [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = (32'(stat_sel) < N_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_multadd_arbiter.sv
// Self-checking bench for multadd_arbiter (N_REQ=4, DATA_W=8, LAT=2).
module tb_multadd_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic [N*2*DW-1:0] req_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*DW:0]     rsp_data;
  logic              flush;
  logic              flush_done;
`ifdef MULTADD_ARB_STATS_EN
  logic [1:0]        stat_sel = '0;
  logic [15:0]       stat_cnt;
`endif

  always #5 clk = ~clk;

  multadd_arbiter #(.N_REQ(N), .DATA_W(DW), .LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef MULTADD_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
`endif
  );

  typedef struct {
    int unsigned id;
    int unsigned data;
  } res_t;

  res_t exp_q[$];
  res_t rsp_log[$];
  int   gnt_log[$];
  bit   mv[L];
  int   mptr;
  bit   mdrain;
  bit   mfd;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input int unsigned a, input int unsigned b, input int unsigned c);
    req_a[i*DW +: DW]     = DW'(a);
    req_b[i*DW +: DW]     = DW'(b);
    req_c[i*2*DW +: 2*DW] = (2*DW)'(c);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
  endtask

  function automatic int unsigned exp_res(input int i);
    int unsigned a, b, c;
    a = int'(req_a[i*DW +: DW]);
    b = int'(req_b[i*DW +: DW]);
    c = int'(req_c[i*2*DW +: 2*DW]);
    return a * b + c;
  endfunction

  function automatic void model_clear();
    foreach (mv[s]) mv[s] = 1'b0;
    exp_q.delete();
    mptr   = 0;
    mdrain = 1'b0;
    mfd    = 1'b0;
  endfunction

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    logic [N-1:0] eg;
    int  gi;
    bit  adv, empty;
    #1;
    adv = !mv[L-1] || rsp_ready;
    eg  = '0;
    gi  = -1;
    if (!mdrain && adv) begin
      for (int k = 0; k < N; k++) begin
        int ix;
        ix = (mptr + k) % N;
        if (gi < 0 && req_valid[ix]) begin
          gi     = ix;
          eg[ix] = 1'b1;
        end
      end
    end
    check("req_ready", req_ready, eg);
    check("rsp_valid", rsp_valid, mv[L-1]);
    if (mv[L-1] && exp_q.size() > 0) begin
      check("rsp_id", rsp_id, exp_q[0].id);
      check("rsp_data", rsp_data, exp_q[0].data);
    end
    check("flush_done", flush_done, mfd && flush);
    empty = 1'b1;
    foreach (mv[s]) if (mv[s]) empty = 1'b0;
    mfd    = mdrain && flush && empty;
    mdrain = flush;
    if (mv[L-1] && rsp_ready && exp_q.size() > 0) begin
      res_t o;
      o.id   = rsp_id;
      o.data = rsp_data;
      rsp_log.push_back(o);
      void'(exp_q.pop_front());
    end
    if (gi >= 0) begin
      res_t e;
      e.id   = gi;
      e.data = exp_res(gi);
      exp_q.push_back(e);
      gnt_log.push_back(gi);
      mptr = (gi + 1) % N;
    end
    if (adv) begin
      for (int s = L - 1; s > 0; s--) mv[s] = mv[s-1];
      mv[0] = (gi >= 0);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    req_valid = '1;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_flush_done", flush_done, 0);
    model_clear();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    rsp_ready = 1'b1; flush = 1'b0;
    do_reset();

    // Single request from id 2
    set_op(2, 3, 5, 7);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (3) step();
    check("single_cnt", rsp_log.size(), 1);
    if (rsp_log.size() > 0) begin
      check("single_id", rsp_log[0].id, 2);
      check("single_data", rsp_log[0].data, 22);
    end

    // Fairness from reset
    do_reset();
    gnt_log.delete(); rsp_log.delete();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin rand_ops(); step(); end
    drain();
    for (int i = 0; i < 8; i++) check("fair_order", (gnt_log.size() > i) ? gnt_log[i] : 99, i % 4);
    check("fair_rsp_cnt", rsp_log.size(), 8);

    // Maximum operands
    rsp_log.delete();
    set_op(0, 255, 255, 65535);
    req_valid = 4'b0001;
    step();
    drain();
    if (rsp_log.size() > 0) check("max_data", rsp_log[0].data, 130560);
    else check("max_cnt", rsp_log.size(), 1);

    // Backpressure: fill, stall 3 cycles, release
    rsp_log.delete();
    rand_ops();
    req_valid = '1;
    repeat (3) step();
    rsp_ready = 1'b0;
    repeat (3) step();
    drain();
    check("bp_rsp_cnt", rsp_log.size(), 3);
    for (int i = 0; i < 3; i++) check("bp_order", (rsp_log.size() > i) ? rsp_log[i].id : 99, i + 1);

    // Random traffic with random backpressure
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Flush / drain
    do_reset();
    gnt_log.delete();
    rand_ops();
    req_valid = 4'b0011;
    repeat (2) step();
    flush = 1'b1;
    req_valid = '1;
    step();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (flush_done) seen = 1'b1;
    end
    check("flush_done_seen", seen, 1);
    check("flush_grants", gnt_log.size(), 3);
    flush = 1'b0;
    repeat (2) step();
    drain();
    for (int i = 0; i < 4; i++) check("flush_order", (gnt_log.size() > i) ? gnt_log[i] : 99, i);

    // Reset with operations in flight
    rand_ops();
    req_valid = '1;
    repeat (3) step();
    do_reset();
    gnt_log.delete(); rsp_log.delete();
    req_valid = '1;
    step();
    drain();
    check("rst_restart", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
    check("rst_rsp_cnt", rsp_log.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
